// File: rtl/mul_booth_seq.sv
// Iterative radix-4 Booth multiplier with start/done handshake and flush.
// One Booth digit is retired per cycle; signed or unsigned mode is chosen per operation.
module mul_booth_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 start,
    input  logic                 signed_op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   z
);

    localparam int EW   = WIDTH + 2;
    localparam int HW   = WIDTH + 3;
    localparam int ITER = WIDTH / 2 + 1;
    localparam int CW   = $clog2(ITER + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state, state_next;
    logic [CW-1:0]         cnt;
    logic signed [EW-1:0]  mcand;
    logic signed [HW-1:0]  hi;
    logic [EW-1:0]         lo;
    logic                  prev;

    logic                  load, step, last, finish;
    logic signed [HW-1:0]  sum, hi_next;
    logic [EW-1:0]         lo_next;
    logic [2*WIDTH-1:0]    product;

    function automatic logic signed [EW-1:0] ext(input logic [WIDTH-1:0] x, input logic s);
        return {{2{s & x[WIDTH-1]}}, x};
    endfunction

    // Partial product for one Booth window {b[2i+1], b[2i], b[2i-1]}.
    function automatic logic signed [HW-1:0] booth_pp(input logic [2:0] win,
                                                      input logic signed [EW-1:0] m);
        logic signed [HW-1:0] m1, m2;
        m1 = {m[EW-1], m};
        m2 = {m, 1'b0};
        case (win)
            3'b001, 3'b010: return m1;
            3'b011:         return m2;
            3'b100:         return -m2;
            3'b101, 3'b110: return -m1;
            default:        return '0;
        endcase
    endfunction

    always_comb begin
        sum     = hi + booth_pp({lo[1:0], prev}, mcand);
        hi_next = sum >>> 2;
        lo_next = {sum[1:0], lo[EW-1:2]};
        product = {hi_next[WIDTH-3:0], lo_next};
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        last       = (cnt == CW'(ITER - 1));
        case (state)
            IDLE: if (start) begin
                load       = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_next = DONE;
                    finish     = 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Cancellation wins over everything but reset and keeps z untouched.
        if (flush) begin
            state_next = IDLE;
            load       = 1'b0;
            step       = 1'b0;
            finish     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            z     <= '0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            done  <= (state_next == DONE);
            if (load)
                cnt <= '0;
            else if (step)
                cnt <= cnt + 1'b1;
            if (finish)
                z <= product;
        end
    end

    // Datapath registers carry no reset; they are reloaded on every accepted start.
    always_ff @(posedge clk) begin
        if (load) begin
            mcand <= ext(a, signed_op);
            hi    <= '0;
            lo    <= ext(b, signed_op);
            prev  <= 1'b0;
        end else if (step) begin
            hi    <= hi_next;
            lo    <= lo_next;
            prev  <= lo[1];
        end
    end

endmodule
